// File: rtl/div_clk_monitor.sv
// Divided-clock health monitor: measures the rise-to-rise period of div_clk_in in clk cycles
// and reports lock, bad periods and missing edges to control/CSR logic.
module div_clk_monitor #(
  parameter  int DIV      = 3,
  parameter  int TOL      = 0,
  parameter  int LOCK_CNT = 4,
  parameter  int TIMEOUT  = 2*DIV,
  localparam int CNT_W    = $clog2(TIMEOUT+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_clk_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             timeout,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam int                GOOD_W    = $clog2(LOCK_CNT+1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT-1);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT, MEASURE, LOCKED} state_e;

  function automatic logic period_ok(input logic [CNT_W-1:0] c);
    int diff;
    diff = int'(c) - DIV;
    return (diff <= TOL) && (diff >= -TOL);
  endfunction

  function automatic logic [7:0] err_cnt_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          sync_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic                vld_q, vld_d;
  logic                locked_q, locked_d;
  logic                tmo_q, tmo_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic rise, measuring, good, tmo_hit, err_evt;

  // sync_q[1:0] is the synchroniser, sync_q[2] the edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], div_clk_in};
  end

  assign rise      = sync_q[1] & ~sync_q[2];
  assign measuring = (state_q == MEASURE) || (state_q == LOCKED);
  assign good      = period_ok(cnt_q);
  assign tmo_hit   = measuring && !rise && (cnt_q == CNT_MAX);
  assign err_evt   = en && (measuring && rise ? !good : tmo_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = WAIT;
        WAIT:    if (rise) state_d = MEASURE;
        MEASURE: if (tmo_hit) state_d = WAIT;
                 else if (rise && good && good_q == GOOD_LAST) state_d = LOCKED;
        LOCKED:  if (tmo_hit) state_d = WAIT;
                 else if (rise && !good) state_d = MEASURE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    good_d    = good_q;
    period_d  = period_q;
    vld_d     = 1'b0;
    tmo_d     = 1'b0;
    locked_d  = locked_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (!en) begin
      cnt_d    = '0;
      good_d   = '0;
      locked_d = 1'b0;
    end else begin
      if (err_clr) begin
        err_d     = 1'b0;
        err_cnt_d = '0;
      end
      case (state_q)
        WAIT: if (rise) cnt_d = CNT_ONE;
        MEASURE, LOCKED: begin
          if (rise) begin
            period_d = cnt_q;
            vld_d    = 1'b1;
            cnt_d    = CNT_ONE;
            if (good) begin
              // good_q saturates at LOCK_CNT while locked
              if (good_q < GOOD_MAX) good_d = good_q + GOOD_ONE;
              if (state_q == MEASURE && good_q == GOOD_LAST) locked_d = 1'b1;
            end else begin
              good_d   = '0;
              locked_d = 1'b0;
            end
          end else if (cnt_q == CNT_MAX) begin
            tmo_d    = 1'b1;
            good_d   = '0;
            locked_d = 1'b0;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: cnt_d = '0;
      endcase
      // an error in the same cycle as err_clr leaves a fresh count of one
      if (err_evt) begin
        err_d     = 1'b1;
        err_cnt_d = err_clr ? 8'd1 : err_cnt_inc(err_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      good_q    <= '0;
      period_q  <= '0;
      vld_q     <= 1'b0;
      locked_q  <= 1'b0;
      tmo_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      good_q    <= good_d;
      period_q  <= period_d;
      vld_q     <= vld_d;
      locked_q  <= locked_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign period     = period_q;
  assign period_vld = vld_q;
  assign locked     = locked_q;
  assign timeout    = tmo_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Scoreboard bench for div_clk_monitor: directed div_clk_in waveforms push expected
// period/timeout reports; a monitor pops and compares each report the DUT presents.
module tb_div_clk_monitor;

  localparam int DIV      = 3;
  localparam int TOL      = 0;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 6;
  localparam int CNT_W    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             div_clk_in;
  logic             err_clr;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             locked;
  logic             timeout;
  logic             err;
  logic [7:0]       err_cnt;

  div_clk_monitor #(
    .DIV(DIV), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_clk_in(div_clk_in), .err_clr(err_clr),
    .period(period), .period_vld(period_vld), .locked(locked), .timeout(timeout),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_tmo;
    int per;
    bit lk;
    bit er;
    int ec;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_vld_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every report the DUT presents must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (period_vld || timeout)) begin
      chk("vld_tmo_exclusive", int'(period_vld && timeout), 0);
      if (sb.size() == 0) begin
        chk("unexpected_report", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("report_kind_timeout", int'(timeout), int'(e.is_tmo));
        chk("period", int'(period), e.per);
        chk("locked", int'(locked), int'(e.lk));
        chk("err", int'(err), int'(e.er));
        chk("err_cnt", int'(err_cnt), e.ec);
        if (e.gap >= 0) chk("timeout_gap", cyc - last_vld_cyc, e.gap);
      end
      if (period_vld) last_vld_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_low(input int n);
    div_clk_in = 1'b0;
    repeat (n) tick();
  endtask

  // Drive a rising edge followed by a p-cycle period; the rise closes the previous interval
  task automatic rise_then(input int p, input bit push, input int per, input bit lk,
                           input bit er, input int ec, input int clr_at);
    if (push) sb.push_back('{1'b0, per, lk, er, ec, -1});
    for (int i = 0; i < p; i++) begin
      div_clk_in = (i < (p + 1) / 2);
      err_clr    = (i == clr_at);
      tick();
    end
    err_clr = 1'b0;
  endtask

  task automatic first(input int p);
    rise_then(p, 1'b0, 0, 1'b0, 1'b0, 0, -1);
  endtask

  task automatic vec(input int p, input int per, input bit lk, input bit er, input int ec);
    rise_then(p, 1'b1, per, lk, er, ec, -1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"},     int'(period), 0);
    chk({tag, "_period_vld"}, int'(period_vld), 0);
    chk({tag, "_locked"},     int'(locked), 0);
    chk({tag, "_timeout"},    int'(timeout), 0);
    chk({tag, "_err"},        int'(err), 0);
    chk({tag, "_err_cnt"},    int'(err_cnt), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    div_clk_in = 1'b0;
    err_clr    = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    en = 1'b1;
    hold_low(4);

    // Clean divider: lock on the 4th period report
    first(3);
    vec(3, 3, 0, 0, 0);
    vec(3, 3, 0, 0, 0);
    vec(3, 3, 0, 0, 0);
    vec(3, 3, 1, 0, 0);
    vec(3, 3, 1, 0, 0);

    // Missing edges: timeout 6 cycles after the last period report
    sb.push_back('{1'b1, 3, 1'b0, 1'b1, 1, 6});
    hold_low(14);

    // Restart from WAIT, relock, then one stretched period
    first(3);
    vec(3, 3, 0, 1, 1);
    vec(3, 3, 0, 1, 1);
    vec(3, 3, 0, 1, 1);
    vec(4, 3, 1, 1, 1);
    vec(3, 4, 0, 1, 2);
    vec(3, 3, 0, 1, 2);
    vec(3, 3, 0, 1, 2);
    vec(3, 3, 0, 1, 2);
    vec(3, 3, 1, 1, 2);

    // err_clr together with a bad period, then err_clr alone
    vec(4, 3, 1, 1, 2);
    rise_then(3, 1'b1, 4, 1'b0, 1'b1, 1, 2);
    rise_then(3, 1'b1, 3, 1'b0, 1'b0, 0, 2);
    vec(3, 3, 0, 0, 0);
    vec(3, 3, 0, 0, 0);
    vec(3, 3, 1, 0, 0);
    hold_low(2);
    chk("locked_before_reset", int'(locked), 1);

    // Asynchronous reset in the middle of a clock phase
    chk("sb_empty_before_reset", sb.size(), 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    hold_low(3);
    first(3);
    vec(3, 3, 0, 0, 0);
    vec(3, 3, 0, 0, 0);
    vec(3, 3, 0, 0, 0);
    vec(3, 3, 1, 0, 0);

    // Bad period to set err, relock, then drop enable while locked
    vec(5, 3, 1, 0, 0);
    vec(3, 5, 0, 1, 1);
    vec(3, 3, 0, 1, 1);
    vec(3, 3, 0, 1, 1);
    vec(3, 3, 0, 1, 1);
    vec(3, 3, 1, 1, 1);
    hold_low(2);
    en = 1'b0;
    tick();
    chk("en_drop_locked", int'(locked), 0);
    chk("en_drop_err", int'(err), 1);
    chk("en_drop_err_cnt", int'(err_cnt), 1);
    chk("en_drop_period", int'(period), 3);
    hold_low(12);
    chk("en_low_err_cnt", int'(err_cnt), 1);
    en = 1'b1;
    hold_low(3);
    first(3);
    vec(3, 3, 0, 1, 1);
    vec(3, 3, 0, 1, 1);
    vec(3, 3, 0, 1, 1);
    vec(3, 3, 1, 1, 1);
    hold_low(4);
    en = 1'b0;
    tick();

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
